// File: rtl/clb_param_pkg.sv
// Shared types and frame layout for the clb_param configurable logic block.
// Cell frame: mem[2^K] then out_sel, fb_sel, q_init, sr_mode[1:0] at the offsets below.
package clb_param_pkg;

    typedef enum logic [1:0] {
        ST_UNCONFIG = 2'd0,
        ST_LOADING  = 2'd1,
        ST_ACTIVE   = 2'd2
    } clb_state_e;

    localparam logic [1:0] SR_NONE = 2'b00;
    localparam logic [1:0] SR_SET  = 2'b01;
    localparam logic [1:0] SR_CLR  = 2'b10;
    localparam logic [1:0] SR_RSVD = 2'b11;

    localparam int OFF_OUT_SEL = 0;
    localparam int OFF_FB_SEL  = 1;
    localparam int OFF_Q_INIT  = 2;
    localparam int OFF_SR_MODE = 3;

    function automatic int cell_bits(input int lut_k);
        return (1 << lut_k) + 5;
    endfunction

endpackage

// File: rtl/clb_lut_cell.sv
// One LUT cell: LUT read, optional self-feedback on the top input, cell flop
// with synchronous set/reset, and the combinational/registered output mux.
module clb_lut_cell
    import clb_param_pkg::*;
#(
    parameter int LUT_K = 4
) (
    input  logic                    K,
    input  logic                    RST,
    input  logic                    i_active,
    input  logic                    i_run,
    input  logic                    i_load,
    input  logic                    i_init,
    input  logic                    i_ce,
    input  logic                    i_sr,
    input  logic [LUT_K-1:0]        i_din,
    input  logic [(1<<LUT_K)-1:0]   i_mem,
    input  logic                    i_out_sel,
    input  logic                    i_fb_sel,
    input  logic [1:0]              i_sr_mode,
    output logic                    o_y
);

    logic             r_q;
    logic [LUT_K-1:0] w_idx;
    logic             w_f;

    // Feedback comes from the flop, so no combinational loop can form.
    assign w_idx = {i_fb_sel ? r_q : i_din[LUT_K-1], i_din[LUT_K-2:0]};
    assign w_f   = i_mem[w_idx];
    assign o_y   = i_active ? (i_out_sel ? r_q : w_f) : 1'b0;

    always_ff @(posedge K) begin
        if (RST) begin
            r_q <= 1'b0;
        end else if (i_load) begin
            r_q <= i_init;
        end else if (!i_run) begin
            r_q <= 1'b0;
        end else begin
            case (i_sr_mode)
                SR_SET: begin
                    if (i_sr)      r_q <= 1'b1;
                    else if (i_ce) r_q <= w_f;
                end
                SR_CLR: begin
                    if (i_sr)      r_q <= 1'b0;
                    else if (i_ce) r_q <= w_f;
                end
                SR_NONE, SR_RSVD: begin
                    if (i_ce) r_q <= w_f;
                end
            endcase
        end
    end

endmodule

// File: rtl/clb_param.sv
// Configurable logic block top: serial config shift register, bit counter and load FSM.
// Define CLB_PARAM_READBACK_EN to add cfg_dout (old frame streams out bit 0 first).
//
// state       | meaning
// UNCONFIG    | after reset, outputs forced low, waiting for cfg_start
// LOADING     | shifting in FRAME_BITS valid bits, outputs forced low
// ACTIVE      | configured, cells running
module clb_param
    import clb_param_pkg::*;
#(
    parameter int LUT_K   = 4,
    parameter int NUM_LUT = 2
) (
    input  logic                       K,
    input  logic                       RST,
    input  logic                       cfg_start,
    input  logic                       cfg_valid,
    input  logic                       cfg_din,
    output logic                       cfg_done,
    input  logic                       ce,
    input  logic [NUM_LUT-1:0]         sr_in,
    input  logic [NUM_LUT*LUT_K-1:0]   din,
    output logic [NUM_LUT-1:0]         Y
`ifdef CLB_PARAM_READBACK_EN
    ,
    output logic                       cfg_dout
`endif
);

    localparam int MEM_BITS   = 1 << LUT_K;
    localparam int CELL_BITS  = cell_bits(LUT_K);
    localparam int FRAME_BITS = NUM_LUT * CELL_BITS;
    localparam int CW         = $clog2(FRAME_BITS);

    clb_state_e              r_state;
    logic [CW-1:0]           r_cnt;
    logic [FRAME_BITS-1:0]   r_frame;
    logic                    r_done;
    logic [FRAME_BITS-1:0]   w_next;
    logic                    w_shift;
    logic                    w_last;
    logic                    w_load;
    logic                    w_active;
    logic                    w_run;

    assign w_next   = {cfg_din, r_frame[FRAME_BITS-1:1]};
    assign w_shift  = (r_state == ST_LOADING) && cfg_valid && !cfg_start;
    assign w_last   = (r_cnt == CW'(FRAME_BITS - 1));
    assign w_load   = w_shift && w_last;
    assign w_active = (r_state == ST_ACTIVE);
    assign w_run    = w_active && !cfg_start;
    assign cfg_done = r_done;

    always_ff @(posedge K) begin
        if (RST) begin
            r_state <= ST_UNCONFIG;
            r_cnt   <= '0;
            r_frame <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_UNCONFIG, ST_ACTIVE: begin
                    if (cfg_start) begin
                        r_state <= ST_LOADING;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                    end
                end
                ST_LOADING: begin
                    // A restart discards any bit presented in the same cycle.
                    if (cfg_start) begin
                        r_cnt <= '0;
                    end else if (cfg_valid) begin
                        r_frame <= w_next;
                        if (w_last) begin
                            r_state <= ST_ACTIVE;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_UNCONFIG;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef CLB_PARAM_READBACK_EN
    logic r_dout;

    always_ff @(posedge K) begin
        if (RST)          r_dout <= 1'b0;
        else if (w_shift) r_dout <= r_frame[0];
    end

    assign cfg_dout = r_dout;
`endif

    for (genvar g = 0; g < NUM_LUT; g++) begin : g_cell
        localparam int BASE = g * CELL_BITS;

        // q_init comes from the post-shift frame so the final bit is honoured.
        clb_lut_cell #(.LUT_K(LUT_K)) u_cell (
            .K         (K),
            .RST       (RST),
            .i_active  (w_active),
            .i_run     (w_run),
            .i_load    (w_load),
            .i_init    (w_next[BASE + MEM_BITS + OFF_Q_INIT]),
            .i_ce      (ce),
            .i_sr      (sr_in[g]),
            .i_din     (din[g*LUT_K +: LUT_K]),
            .i_mem     (r_frame[BASE +: MEM_BITS]),
            .i_out_sel (r_frame[BASE + MEM_BITS + OFF_OUT_SEL]),
            .i_fb_sel  (r_frame[BASE + MEM_BITS + OFF_FB_SEL]),
            .i_sr_mode (r_frame[BASE + MEM_BITS + OFF_SR_MODE +: 2]),
            .o_y       (Y[g])
        );
    end

endmodule
